// File: rtl/bit_collector_if.sv
// Character-in / word-out bundle for bit_collector.
// The echo signals exist only when BIT_COLLECTOR_ECHO_EN is defined.
interface bit_collector_if #(
    parameter int unsigned NBITS = 8
);
    logic [7:0]       char_in;
    logic             char_valid;
    logic             char_ready;
    logic [3:0]       addr;
    logic [NBITS-1:0] word_out;
    logic             word_valid;
    logic             err;
`ifdef BIT_COLLECTOR_ECHO_EN
    logic [7:0]       echo_out;
    logic             echo_valid;
    logic             echo_ready;
`endif

    // master: character source / word consumer; slave: the collector
    modport master (
        output char_in, char_valid,
        input  char_ready, addr, word_out, word_valid, err
`ifdef BIT_COLLECTOR_ECHO_EN
        , input echo_out, echo_valid,
        output echo_ready
`endif
    );

    modport slave (
        input  char_in, char_valid,
        output char_ready, addr, word_out, word_valid, err
`ifdef BIT_COLLECTOR_ECHO_EN
        , output echo_out, echo_valid,
        input  echo_ready
`endif
    );
endinterface

// File: rtl/bit_collector.sv
// Collects ASCII "0"/"1" characters into an NBITS word and publishes it bit-reversed.
// Define BIT_COLLECTOR_ECHO_EN to add the EMIT state that echoes the word as ASCII.
module bit_collector #(
    parameter int unsigned NBITS = 8
) (
    input  logic           clk,
    input  logic           reset,
    bit_collector_if.slave bus
);

`ifdef BIT_COLLECTOR_ECHO_EN
    typedef enum logic {COLLECT = 1'b0, EMIT = 1'b1} state_t;
`else
    typedef enum logic {COLLECT = 1'b0} state_t;
`endif

    state_t           state_q, state_d;
    logic [3:0]       addr_q, addr_d;
    logic [NBITS-1:0] in_word_q, in_word_d;
    logic [NBITS-1:0] word_out_q, word_out_d;
    logic             word_valid_q, word_valid_d;
    logic             err_q, err_d;
    logic             char_ready;
    logic             accept;
    logic             is_bit;
    logic [NBITS-1:0] bit_mask;
`ifdef BIT_COLLECTOR_ECHO_EN
    logic [7:0]       echo_out_q, echo_out_d;
    logic             echo_valid_q, echo_valid_d;
    logic [3:0]       echo_cnt_q, echo_cnt_d;
    logic [NBITS-1:0] echo_shift;
`endif

    assign char_ready = (state_q == COLLECT);
    assign accept     = bus.char_valid && char_ready;
    assign is_bit     = (bus.char_in == 8'h30) || (bus.char_in == 8'h31);
    assign bit_mask   = NBITS'(1) << addr_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        in_word_d    = in_word_q;
        word_out_d   = word_out_q;
        word_valid_d = 1'b0;
        err_d        = 1'b0;
`ifdef BIT_COLLECTOR_ECHO_EN
        echo_out_d   = echo_out_q;
        echo_valid_d = echo_valid_q;
        echo_cnt_d   = echo_cnt_q;
        echo_shift   = '0;
`endif
        if (accept) begin
            if (is_bit) begin
                in_word_d = bus.char_in[0] ? (in_word_q | bit_mask) : (in_word_q & ~bit_mask);
                if (addr_q == 4'(NBITS - 1)) begin
                    addr_d       = '0;
                    word_out_d   = {<<{in_word_d}};
                    word_valid_d = 1'b1;
`ifdef BIT_COLLECTOR_ECHO_EN
                    // first echo character goes out alongside word_valid
                    state_d      = EMIT;
                    echo_valid_d = 1'b1;
                    echo_cnt_d   = '0;
                    echo_out_d   = {7'b0011000, word_out_d[0]};
`endif
                end else begin
                    addr_d = addr_q + 4'd1;
                end
            end else begin
                err_d = 1'b1;
            end
        end
`ifdef BIT_COLLECTOR_ECHO_EN
        if ((state_q == EMIT) && echo_valid_q && bus.echo_ready) begin
            if (echo_cnt_q == 4'(NBITS - 1)) begin
                state_d      = COLLECT;
                echo_valid_d = 1'b0;
                echo_cnt_d   = '0;
            end else begin
                echo_cnt_d = echo_cnt_q + 4'd1;
                echo_shift = word_out_q >> echo_cnt_d;
                echo_out_d = {7'b0011000, echo_shift[0]};
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= COLLECT;
            addr_q       <= '0;
            in_word_q    <= '0;
            word_out_q   <= '0;
            word_valid_q <= 1'b0;
            err_q        <= 1'b0;
`ifdef BIT_COLLECTOR_ECHO_EN
            echo_out_q   <= 8'h30;
            echo_valid_q <= 1'b0;
            echo_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            in_word_q    <= in_word_d;
            word_out_q   <= word_out_d;
            word_valid_q <= word_valid_d;
            err_q        <= err_d;
`ifdef BIT_COLLECTOR_ECHO_EN
            echo_out_q   <= echo_out_d;
            echo_valid_q <= echo_valid_d;
            echo_cnt_q   <= echo_cnt_d;
`endif
        end
    end

    assign bus.char_ready = char_ready;
    assign bus.addr       = addr_q;
    assign bus.word_out   = word_out_q;
    assign bus.word_valid = word_valid_q;
    assign bus.err        = err_q;
`ifdef BIT_COLLECTOR_ECHO_EN
    assign bus.echo_out   = echo_out_q;
    assign bus.echo_valid = echo_valid_q;
`endif

endmodule

// File: tb/tb_bit_collector.sv
// Directed self-checking bench for bit_collector (NBITS=8); echo checks
// are compiled in when BIT_COLLECTOR_ECHO_EN is defined.
module tb_bit_collector;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    bit_collector_if #(.NBITS(8)) bus ();

    bit_collector #(.NBITS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] seq_a [8] = '{8'h30, 8'h31, 8'h30, 8'h30, 8'h31, 8'h31, 8'h31, 8'h31};
    logic [7:0] echo_a [8] = '{8'h31, 8'h31, 8'h31, 8'h31, 8'h30, 8'h30, 8'h31, 8'h30};
    logic [15:0] d_sh;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c);
        bus.char_in    = c;
        bus.char_valid = 1'b1;
        tick();
    endtask

    // Lets a pending echo run out so collection can resume
    task automatic drain;
        bus.char_valid = 1'b0;
`ifdef BIT_COLLECTOR_ECHO_EN
        bus.echo_ready = 1'b1;
        repeat (8) tick();
        check("drain_echo_valid", bus.echo_valid, 0);
        check("drain_char_ready", bus.char_ready, 1);
        bus.echo_ready = 1'b0;
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        bus.char_in    = 8'h30;
        bus.char_valid = 1'b0;
`ifdef BIT_COLLECTOR_ECHO_EN
        bus.echo_ready = 1'b0;
`endif
        #12;
        check("rst_addr", bus.addr, 0);
        check("rst_word_out", bus.word_out, 0);
        check("rst_word_valid", bus.word_valid, 0);
        check("rst_err", bus.err, 0);
`ifdef BIT_COLLECTOR_ECHO_EN
        check("rst_echo_valid", bus.echo_valid, 0);
        check("rst_echo_out", bus.echo_out, 8'h30);
`endif
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("post_rst_char_ready", bus.char_ready, 1);

        // Word "01001111" -> in_word F2, word_out 4F
        for (int i = 0; i < 8; i++) begin
            send(seq_a[i]);
            check("A_addr", bus.addr, (i == 7) ? 0 : i + 1);
            check("A_word_valid", bus.word_valid, (i == 7) ? 1 : 0);
        end
        check("A_word_out", bus.word_out, 8'h4F);
        bus.char_valid = 1'b0;
`ifdef BIT_COLLECTOR_ECHO_EN
        bus.echo_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("A_echo_valid", bus.echo_valid, 1);
            check("A_echo_out", bus.echo_out, echo_a[k]);
            check("A_emit_char_ready", bus.char_ready, 0);
            tick();
        end
        check("A_echo_done", bus.echo_valid, 0);
        check("A_back_collect", bus.char_ready, 1);
        bus.echo_ready = 1'b0;
`else
        tick();
`endif
        check("A_word_valid_drop", bus.word_valid, 0);
        check("A_word_out_hold", bus.word_out, 8'h4F);

        // "1","x","0": invalid char flagged and skipped
        send(8'h31);
        check("B_addr1", bus.addr, 1);
        check("B_err1", bus.err, 0);
        send(8'h78);
        check("B_addr_x", bus.addr, 1);
        check("B_err_x", bus.err, 1);
        send(8'h30);
        check("B_addr2", bus.addr, 2);
        check("B_err_clear", bus.err, 0);
        for (int i = 0; i < 6; i++) begin
            send(8'h31);
            check("B_addr_fill", bus.addr, (i == 5) ? 0 : i + 3);
        end
        check("B_word_valid", bus.word_valid, 1);
        check("B_word_out", bus.word_out, 8'hBF);
        drain();

        // Reset mid-word discards the partial word
        for (int i = 0; i < 5; i++) begin
            send((i % 2 == 1) ? 8'h31 : 8'h30);
        end
        check("C_addr_partial", bus.addr, 5);
        bus.char_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("C_async_addr", bus.addr, 0);
        check("C_async_word_out", bus.word_out, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("C_char_ready", bus.char_ready, 1);
        for (int i = 0; i < 8; i++) begin
            send(8'h31);
        end
        check("C_word_valid", bus.word_valid, 1);
        check("C_word_out", bus.word_out, 8'hFF);
        drain();

        // Words F2 then 01, LSB first
        d_sh = 16'h01F2;
        for (int i = 0; i < 16; i++) begin
            send(d_sh[0] ? 8'h31 : 8'h30);
            d_sh = d_sh >> 1;
            check("D_word_valid", bus.word_valid, (i == 7 || i == 15) ? 1 : 0);
            if (i >= 7 && i < 15) check("D_word_out1", bus.word_out, 8'h4F);
            if (i == 15) check("D_word_out2", bus.word_out, 8'h80);
            if (i == 7) drain();
        end
        drain();

`ifdef BIT_COLLECTOR_ECHO_EN
        // Back-pressure during EMIT; input characters are ignored
        for (int i = 0; i < 8; i++) begin
            send(seq_a[i]);
        end
        bus.char_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.char_in    = 8'h31;
            bus.char_valid = 1'b1;
            tick();
            check("E_stall_echo_out", bus.echo_out, 8'h31);
            check("E_stall_echo_valid", bus.echo_valid, 1);
            check("E_stall_char_ready", bus.char_ready, 0);
            check("E_stall_addr", bus.addr, 0);
        end
        bus.char_valid = 1'b0;
        bus.echo_ready = 1'b1;
        repeat (3) tick();
        check("E_mid_echo_valid", bus.echo_valid, 1);
        check("E_mid_echo_out", bus.echo_out, 8'h31);

        // Asynchronous reset in EMIT
        reset = 1'b1;
        #1;
        check("E_rst_echo_valid", bus.echo_valid, 0);
        check("E_rst_addr", bus.addr, 0);
        check("E_rst_char_ready", bus.char_ready, 1);
        check("E_rst_echo_out", bus.echo_out, 8'h30);
        bus.echo_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        tick();
        send(8'h31);
        check("E_first_bit_addr", bus.addr, 1);
        for (int i = 0; i < 7; i++) begin
            send(8'h30);
        end
        check("E_word_out", bus.word_out, 8'h80);
        drain();
`endif

        tick();
        check("end_word_valid", bus.word_valid, 0);
        check("end_err", bus.err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
